// File: rtl/slot_pkg.sv
// Shared constants for the slot-machine wager logic: balance width/limit,
// FSM state codes and the fixed credit denominations.
// Pure declarations; no timing or flow-control behaviour of its own.
package slot_pkg;

  localparam int BAL_W   = 11;
  localparam int BAL_MAX = 2047;

  // FSM state codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SPIN   = 2'd1;
  localparam logic [1:0] ST_STATUS = 2'd2;

  // Credit denominations
  localparam logic [BAL_W-1:0] AMT_5  = 11'd5;
  localparam logic [BAL_W-1:0] AMT_10 = 11'd10;
  localparam logic [BAL_W-1:0] AMT_20 = 11'd20;

  // Largest selected denomination wins; no selection means zero credit.
  function automatic logic [BAL_W-1:0] sel_amt(input logic b5,
                                               input logic b10,
                                               input logic b20);
    logic [BAL_W-1:0] a;
    a = '0;
    if (b20) begin
      a = AMT_20;
    end else if (b10) begin
      a = AMT_10;
    end else if (b5) begin
      a = AMT_5;
    end
    return a;
  endfunction

endpackage

// File: rtl/status_timer.sv
// Holds the status display for a fixed number of cycles after a start pulse.
// Latency: active rises the cycle after start and stays high STATUS_CYCLES cycles.
// No backpressure: a start while already active is not expected and restarts it.
module status_timer #(
  parameter int STATUS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic active,
  output logic last
);

  // Counter only needs to reach STATUS_CYCLES-1; the active flop covers the rest.
  localparam int CW = (STATUS_CYCLES > 1) ? $clog2(STATUS_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(STATUS_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  // Load on start, count down while active, drop active when the count is spent.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = LOAD;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;
  // High during the final held cycle, so the owner can leave in step with active.
  assign last   = active_q && (cnt_q == '0);

endmodule

// File: rtl/wager_sequencer.sv
// Slot-machine wallet/wager FSM: credits, bets, payouts, cash-out and status hold.
// Latency: every accepted request is visible on the registered outputs one cycle later.
// Buttons are only honoured in IDLE; anything arriving while busy is silently dropped.
module wager_sequencer
  import slot_pkg::*;
#(
  parameter int STATUS_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cash_out_btn,
  input  logic             add_btn,
  input  logic             gamble_btn,
  input  logic             status_btn,
  input  logic             buffer_5,
  input  logic             buffer_10,
  input  logic             buffer_20,
  input  logic             spin_done,
  input  logic [2:0]       win_mult,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W-1:0] money_invested,
  output logic             run_game,
  output logic [BAL_W-1:0] bet,
  output logic             cash_out_valid,
  output logic [BAL_W-1:0] cash_out_amt,
  output logic             show_status,
  output logic             err,
  output logic             busy
);

  localparam int SUM_W = BAL_W + 1;
  localparam int WIN_W = 14;

  logic [1:0]       state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [BAL_W-1:0] invested_q, invested_d;
  logic [BAL_W-1:0] bet_q, bet_d;
  logic [BAL_W-1:0] cash_amt_q, cash_amt_d;
  logic             run_game_q, run_game_d;
  logic             cash_vld_q, cash_vld_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             timer_start;
  logic             timer_active;
  logic             timer_last;

  logic [BAL_W-1:0] amt;
  logic [SUM_W-1:0] add_bal, add_inv;
  logic [WIN_W-1:0] win_prod, win_sum;

  // Arithmetic is one bit wider than the balance for adds and 14 bits for
  // payouts, so overflow is detected rather than wrapped.
  assign amt      = sel_amt(buffer_5, buffer_10, buffer_20);
  assign add_bal  = {1'b0, balance_q} + {1'b0, amt};
  assign add_inv  = {1'b0, invested_q} + {1'b0, amt};
  assign win_prod = WIN_W'(bet_q) * WIN_W'(win_mult);
  assign win_sum  = WIN_W'(balance_q) + win_prod;

  // Next-state and datapath decisions; requests resolved cash_out > status > add > gamble.
  always_comb begin
    state_d     = state_q;
    balance_d   = balance_q;
    invested_d  = invested_q;
    bet_d       = bet_q;
    cash_amt_d  = cash_amt_q;
    run_game_d  = run_game_q;
    cash_vld_d  = 1'b0;
    err_d       = 1'b0;
    timer_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cash_out_btn) begin
          cash_amt_d = balance_q;
          cash_vld_d = 1'b1;
          balance_d  = '0;
          invested_d = '0;
        end else if (status_btn) begin
          state_d     = ST_STATUS;
          timer_start = 1'b1;
        end else if (add_btn) begin
          // An add that would overflow either register is refused as a whole.
          if ((amt == '0) || (add_bal > SUM_W'(BAL_MAX)) ||
              (add_inv > SUM_W'(BAL_MAX))) begin
            err_d = 1'b1;
          end else begin
            balance_d  = add_bal[BAL_W-1:0];
            invested_d = add_inv[BAL_W-1:0];
          end
        end else if (gamble_btn) begin
          if ((amt == '0) || (balance_q < amt)) begin
            err_d = 1'b1;
          end else begin
            balance_d  = balance_q - amt;
            bet_d      = amt;
            run_game_d = 1'b1;
            state_d    = ST_SPIN;
          end
        end
      end
      ST_SPIN: begin
        if (spin_done) begin
          // Winnings saturate at the balance ceiling instead of wrapping.
          if (win_sum > WIN_W'(BAL_MAX)) begin
            balance_d = BAL_W'(BAL_MAX);
          end else begin
            balance_d = win_sum[BAL_W-1:0];
          end
          run_game_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_STATUS: begin
        if (timer_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        run_game_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Register every output; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      balance_q  <= '0;
      invested_q <= '0;
      bet_q      <= '0;
      cash_amt_q <= '0;
      run_game_q <= 1'b0;
      cash_vld_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      balance_q  <= balance_d;
      invested_q <= invested_d;
      bet_q      <= bet_d;
      cash_amt_q <= cash_amt_d;
      run_game_q <= run_game_d;
      cash_vld_q <= cash_vld_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  status_timer #(
    .STATUS_CYCLES(STATUS_CYCLES)
  ) u_status_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .active(timer_active),
    .last  (timer_last)
  );

  assign balance        = balance_q;
  assign money_invested = invested_q;
  assign run_game       = run_game_q;
  assign bet            = bet_q;
  assign cash_out_valid = cash_vld_q;
  assign cash_out_amt   = cash_amt_q;
  assign show_status    = timer_active;
  assign err            = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_wager_sequencer.sv
// Self-checking bench: behavioural wallet model compared every cycle, plus
// directed scenarios with hand-computed values and a randomized soak.
// Inputs change 1 time unit after the rising edge; outputs compared on the falling edge.
module tb_wager_sequencer;

  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cash_out_btn, add_btn, gamble_btn, status_btn;
  logic        buffer_5, buffer_10, buffer_20;
  logic        spin_done;
  logic [2:0]  win_mult;
  logic [10:0] balance, money_invested, bet, cash_out_amt;
  logic        run_game, cash_out_valid, show_status, err, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wager_sequencer #(.STATUS_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .cash_out_btn(cash_out_btn), .add_btn(add_btn),
    .gamble_btn(gamble_btn), .status_btn(status_btn),
    .buffer_5(buffer_5), .buffer_10(buffer_10), .buffer_20(buffer_20),
    .spin_done(spin_done), .win_mult(win_mult),
    .balance(balance), .money_invested(money_invested),
    .run_game(run_game), .bet(bet),
    .cash_out_valid(cash_out_valid), .cash_out_amt(cash_out_amt),
    .show_status(show_status), .err(err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for a request, 1 spinning, 2 showing status
  int m_mode, m_left, m_bal, m_inv, m_bet, m_camt, m_amt;
  bit m_run, m_cov, m_err, m_show, m_started;

  initial begin
    m_started = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_left = 0; m_bal = 0; m_inv = 0; m_bet = 0; m_camt = 0;
      m_run = 0; m_cov = 0; m_err = 0; m_show = 0; m_started = 1'b1;
    end else begin
      m_err = 0;
      m_cov = 0;
      m_amt = buffer_20 ? 20 : buffer_10 ? 10 : buffer_5 ? 5 : 0;
      if (m_mode == 0) begin
        if (cash_out_btn) begin
          m_camt = m_bal; m_cov = 1; m_bal = 0; m_inv = 0;
        end else if (status_btn) begin
          m_mode = 2; m_left = SC; m_show = 1;
        end else if (add_btn) begin
          if (m_amt == 0 || m_bal + m_amt > 2047 || m_inv + m_amt > 2047) m_err = 1;
          else begin
            m_bal += m_amt; m_inv += m_amt;
          end
        end else if (gamble_btn) begin
          if (m_amt == 0 || m_bal < m_amt) m_err = 1;
          else begin
            m_bal -= m_amt; m_bet = m_amt; m_run = 1; m_mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (spin_done) begin
          m_bal = m_bal + m_bet * int'(win_mult);
          if (m_bal > 2047) m_bal = 2047;
          m_run = 0; m_mode = 0;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0; m_show = 0;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      chk("balance",        balance,        m_bal);
      chk("money_invested", money_invested, m_inv);
      chk("bet",            bet,            m_bet);
      chk("cash_out_amt",   cash_out_amt,   m_camt);
      chk("run_game",       run_game,       m_run);
      chk("cash_out_valid", cash_out_valid, m_cov);
      chk("show_status",    show_status,    m_show);
      chk("err",            err,            m_err);
      chk("busy",           busy,           (m_mode != 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_buf(input logic b5, input logic b10, input logic b20);
    buffer_5 = b5; buffer_10 = b10; buffer_20 = b20;
  endtask

  task automatic adds(input int n);
    for (int i = 0; i < n; i++) begin
      add_btn = 1'b1;
      cyc();
    end
    add_btn = 1'b0;
  endtask

  int show_cnt;

  initial begin
    rst = 1'b1;
    cash_out_btn = 0; add_btn = 0; gamble_btn = 0; status_btn = 0;
    set_buf(0, 0, 0);
    spin_done = 0; win_mult = 3'd0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_balance", balance, 0);
    chk("reset_busy", busy, 0);
    chk("reset_run_game", run_game, 0);

    // Three credits of 20
    set_buf(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add_btn = 1'b1;
      cyc();
      add_btn = 1'b0;
      chk("add_err_low", err, 0);
      cyc();
    end
    chk("add3_balance", balance, 60);
    chk("add3_invested", money_invested, 60);

    // Bet 10, win x3
    set_buf(0, 1, 0);
    gamble_btn = 1'b1;
    cyc();
    gamble_btn = 1'b0;
    chk("gamble_balance", balance, 50);
    chk("gamble_bet", bet, 10);
    chk("gamble_run_game", run_game, 1);
    chk("gamble_busy", busy, 1);
    cyc();
    cyc();
    spin_done = 1'b1; win_mult = 3'd3;
    cyc();
    spin_done = 1'b0; win_mult = 3'd0;
    chk("win_balance", balance, 80);
    chk("win_run_game", run_game, 0);

    // Insufficient balance for a 20 bet
    cash_out_btn = 1'b1;
    cyc();
    cash_out_btn = 1'b0;
    set_buf(1, 0, 0);
    adds(1);
    set_buf(0, 0, 1);
    gamble_btn = 1'b1;
    cyc();
    gamble_btn = 1'b0;
    chk("short_err", err, 1);
    chk("short_balance", balance, 5);
    chk("short_run_game", run_game, 0);
    cyc();
    chk("short_err_one_cycle", err, 0);

    // Climb to 2040, then an add of 10 overflows
    adds(101);
    set_buf(0, 1, 0);
    adds(1);
    set_buf(1, 0, 0);
    adds(1);
    chk("climb_balance", balance, 2040);
    set_buf(0, 1, 0);
    adds(1);
    chk("ovf_err", err, 1);
    chk("ovf_balance", balance, 2040);

    // Cash out 2040, rebuild to 80, then add+cash_out together
    cash_out_btn = 1'b1;
    cyc();
    cash_out_btn = 1'b0;
    chk("cash_big_amt", cash_out_amt, 2040);
    set_buf(0, 0, 1);
    adds(4);
    add_btn = 1'b1; cash_out_btn = 1'b1;
    cyc();
    add_btn = 1'b0; cash_out_btn = 1'b0;
    chk("prio_cov", cash_out_valid, 1);
    chk("prio_amt", cash_out_amt, 80);
    chk("prio_balance", balance, 0);
    chk("prio_invested", money_invested, 0);
    cyc();
    chk("prio_cov_one_cycle", cash_out_valid, 0);
    chk("prio_amt_held", cash_out_amt, 80);

    // Status hold with an add arriving mid-display
    status_btn = 1'b1;
    cyc();
    status_btn = 1'b0;
    show_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (show_status === 1'b1) show_cnt++;
      add_btn = (i == 1);
      cyc();
    end
    add_btn = 1'b0;
    chk("status_cycles", show_cnt, SC);
    chk("status_add_ignored", balance, 0);

    // Reset in the middle of a spin
    set_buf(0, 1, 0);
    adds(1);
    gamble_btn = 1'b1;
    cyc();
    gamble_btn = 1'b0;
    chk("abort_bet", bet, 10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_balance", balance, 0);
    chk("abort_invested", money_invested, 0);
    chk("abort_bet_cleared", bet, 0);
    chk("abort_run_game", run_game, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cash_amt", cash_out_amt, 0);
    spin_done = 1'b1; win_mult = 3'd5;
    cyc();
    spin_done = 1'b0; win_mult = 3'd0;
    chk("late_spin_balance", balance, 0);
    chk("late_spin_run_game", run_game, 0);

    // Randomized soak against the model
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      cash_out_btn = ($urandom_range(0, 99) < 2);
      status_btn   = ($urandom_range(0, 99) < 2);
      add_btn      = ($urandom_range(0, 99) < 30);
      gamble_btn   = ($urandom_range(0, 99) < 15);
      buffer_5     = 1'($urandom);
      buffer_10    = 1'($urandom);
      buffer_20    = ($urandom_range(0, 99) < 60);
      spin_done    = ($urandom_range(0, 99) < 20);
      win_mult     = 3'($urandom);
      cyc();
    end
    rst = 0; cash_out_btn = 0; status_btn = 0; add_btn = 0; gamble_btn = 0;
    spin_done = 0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wager_sequencer.md
WAGER_SEQUENCER -- requirements
Module: wager_sequencer

Interface
REQ-001 SHALL have parameter STATUS_CYCLES, default 100000000, number of cycles show_status is held (1 s at 100 MHz).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports cash_out_btn, add_btn, gamble_btn and status_btn, each input, 1, a debounced single-cycle request pulse.
REQ-005 SHALL have ports buffer_5, buffer_10 and buffer_20, each input, 1, a level-selected credit amount.
REQ-006 SHALL have port spin_done, input, 1, a one-cycle pulse from the reel engine ending a spin.
REQ-007 SHALL have port win_mult, input, 3, the payout multiplier, valid only with spin_done.
REQ-008 SHALL have port balance, output, 11, the current player balance.
REQ-009 SHALL have port money_invested, output, 11, the cumulative credit added since the last cash-out.
REQ-010 SHALL have port run_game, output, 1, a level held high throughout a spin.
REQ-011 SHALL have port bet, output, 11, the wager latched for the current spin.
REQ-012 SHALL have ports cash_out_valid, output, 1, and cash_out_amt, output, 11, a one-cycle payout strobe and its value.
REQ-013 SHALL have port show_status, output, 1, a status display enable.
REQ-014 SHALL have ports err, output, 1, a one-cycle rejected-request pulse, and busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, SPIN and STATUS.
REQ-016 SHALL sample buttons only in IDLE; buttons in SPIN or STATUS are dropped, with no queuing and no err.
REQ-017 SHALL resolve simultaneous buttons by fixed priority cash_out > status > add > gamble, and drop lower-priority requests.
REQ-018 SHALL select amount amt as 20 if buffer_20, else 10 if buffer_10, else 5 if buffer_5, else 0.
REQ-019 SHALL, when add or gamble is requested with amt=0, pulse err and leave all registers unchanged.
REQ-020 SHALL, on add in IDLE, set balance<=balance+amt and money_invested<=money_invested+amt at the same edge, staying in IDLE.
REQ-021 SHALL, on add, compute with 12-bit sums; if either sum exceeds 2047, reject the whole add: err pulse, no change.
REQ-022 SHALL, on gamble in IDLE with balance>=amt, set balance<=balance-amt and bet<=amt, go to SPIN, and raise run_game at the same edge.
REQ-023 SHALL, on gamble with balance<amt, pulse err and remain in IDLE.
REQ-024 SHALL, in SPIN, on spin_done, set balance<=min(balance+bet*win_mult, 2047) using a 14-bit product/sum, drop run_game, go to IDLE; win_mult=0 means loss.
REQ-025 SHALL, on cash_out in IDLE, set cash_out_amt<=balance and pulse cash_out_valid for one cycle, and clear balance and money_invested; this is legal with balance 0 (amt 0).
REQ-026 SHALL hold cash_out_amt until the next cash-out or reset.
REQ-027 SHALL, on status in IDLE, go to STATUS and raise show_status for exactly STATUS_CYCLES cycles, then return to IDLE and lower show_status.
REQ-028 SHALL register all outputs, with results visible the cycle after the accepting edge.
REQ-029 SHALL ignore spin_done outside SPIN.

Reset
REQ-030 SHALL, on rst sampled high, go to state IDLE and zero balance, money_invested, bet, cash_out_amt and the status counter.
REQ-031 SHALL, on reset, drive run_game, cash_out_valid, show_status, err and busy to 0.
REQ-032 SHALL abort a spin when rst asserts mid-SPIN, with the wager forfeited, and ignore a later spin_done.
REQ-033 SHALL give rst priority over any simultaneous button or spin_done.

Structure
REQ-034 SHALL take BAL_W=11, BAL_MAX=2047, the state enumeration and the amounts 5/10/20 from shared package slot_pkg.
REQ-035 SHALL place the STATUS hold counter in a sub-module status_timer (start pulse in, active level out, parameter STATUS_CYCLES).

Verification (bench uses STATUS_CYCLES=4)
REQ-036 SHALL check: reset; buffer_20 with add_btn pulsed 3 times -> balance=60, money_invested=60, err never high.
REQ-037 SHALL check: balance=60, buffer_10, gamble_btn -> next cycle balance=50, bet=10, run_game=1, busy=1; then spin_done with win_mult=3 -> balance=80, run_game=0.
REQ-038 SHALL check: balance=5, buffer_20, gamble_btn -> err one cycle, balance=5, run_game=0; then balance=2040 with add 10 -> err, balance=2040.
REQ-039 SHALL check: add_btn and cash_out_btn in the same cycle with balance=80 -> cash_out_valid one cycle, cash_out_amt=80, balance=0, money_invested=0.
REQ-040 SHALL check: status_btn -> show_status high exactly 4 cycles; an add_btn during it is ignored and balance is unchanged.
REQ-041 SHALL check: rst mid-SPIN with bet=10 -> IDLE, all outputs zero, and a later spin_done has no effect.
